// File: rtl/ascon_stream_read_dma.sv
// ascon_stream_read_dma: OBI word-read DMA feeding a byte-realigned,
// word-aligned little-endian valid/ready stream (Ascon datapath feed).
//
// Optional feature macro: ASCON_RDMA_ERR_EN
//   defined   : r.err on any accepted rvalid sets a sticky flag shown as
//               werr on the wlast beat; cleared at command accept.
//   undefined : r.err ignored, werr tied to 0.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   mgr_req_o/mgr_rsp_i OBI manager request / response
//   arvalid/arready     command handshake (araddr, arlen, aruser)
//   wvalid/wready       stream handshake (wdata, wuser, wbe, wlast, werr)
//   busy_o              command in progress

package ascon_rdma_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } mgr_obi_a_t;

  typedef struct packed {
    logic       req;
    mgr_obi_a_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } mgr_obi_r_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    mgr_obi_r_t r;
  } mgr_obi_rsp_t;

endpackage

module ascon_stream_read_dma
  import ascon_rdma_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned USER_W    = 6,
  parameter int unsigned LEN_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output mgr_obi_req_t      mgr_req_o,
  input  mgr_obi_rsp_t      mgr_rsp_i,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [USER_W-1:0] aruser,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [USER_W-1:0] wuser,
  output logic [3:0]        wbe,
  output logic              wlast,
  output logic              werr,
  output logic              busy_o
);

  localparam int CW = $clog2(MAX_OUTST + 1) + 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int NW = LEN_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]       r_addr;
  logic [NW-1:0]     r_rleft;
  logic [1:0]        r_off;
  logic              r_first;
  logic [LEN_W-1:0]  r_bleft;
  logic [USER_W-1:0] r_user;
  logic [CW-1:0]     r_outst;
  logic [CW-1:0]     r_fcnt;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [31:0]       r_mem [MAX_OUTST];
  logic [23:0]       r_res;
  logic [2:0]        r_rcnt;
  logic              r_err;
  logic              r_wvalid;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wbe;
  logic              r_wlast;
  logic              r_werr;

  logic              w_acc;
  logic [LEN_W+1:0]  w_nsum;
  logic [CW-1:0]     w_credit;
  logic              w_req;
  logic              w_gnt;
  logic              w_rx;
  logic [LEN_W+1:0]  w_bl;
  logic [2:0]        w_need;
  logic              w_ld;
  logic              w_res_only;
  logic              w_pop;
  logic [31:0]       w_rdata;
  logic [31:0]       w_sh;
  logic [2:0]        w_avail;
  logic [2:0]        w_total;
  logic [55:0]       w_comb;
  logic              w_beat;
  logic              w_blast;
  logic [3:0]        w_be;
  logic [31:0]       w_mask;
  logic [31:0]       w_bdata;
  logic              w_unused;

  assign w_acc   = arvalid & arready;
  assign arready = (r_state == S_IDLE);
  assign busy_o  = ~arready;

  // Reads needed to cover the unaligned byte range.
  assign w_nsum = (LEN_W+2)'(araddr[1:0])
                + (LEN_W+2)'(arlen)
                + (LEN_W+2)'(3);

  // Credits span in-flight reads and FIFO words, so rvalid can always
  // be pushed without backpressure.
  assign w_credit = r_outst + r_fcnt;
  assign w_req    = (r_state == S_RUN)
                  && (r_rleft != '0)
                  && (w_credit < CW'(MAX_OUTST));
  assign w_gnt    = w_req & mgr_rsp_i.gnt;
  assign w_rx     = mgr_rsp_i.rvalid & (r_outst != '0);

  always_comb begin
    mgr_req_o        = '0;
    mgr_req_o.req    = w_req;
    mgr_req_o.a.addr = r_addr;
    mgr_req_o.a.be   = 4'b1111;
  end

  // Realigner: bytes needed for the next beat (4, or the tail count).
  assign w_bl   = (LEN_W+2)'(r_bleft);
  assign w_need = (w_bl > (LEN_W+2)'(3)) ? 3'd4 : w_bl[2:0];

  // The output register only reloads while the consumer is ready, so a
  // stalled stream also stops FIFO drain and hence new requests.
  assign w_ld       = (r_state == S_RUN) && wready && (r_bleft != '0);
  assign w_res_only = w_ld && (r_rcnt >= w_need);
  assign w_pop      = w_ld && !w_res_only && (r_fcnt != '0);

  assign w_rdata = r_mem[r_rp];
  assign w_sh    = r_first ? (w_rdata >> {r_off, 3'b000}) : w_rdata;
  assign w_avail = r_first ? (3'd4 - {1'b0, r_off}) : 3'd4;
  assign w_total = r_rcnt + w_avail;
  assign w_comb  = {32'b0, r_res}
                 | ({24'b0, w_sh} << {r_rcnt, 3'b000});

  assign w_beat  = w_res_only || (w_pop && (w_total >= w_need));
  assign w_blast = (w_bl == (LEN_W+2)'(w_need));

  always_comb begin
    w_be = 4'b1111;
    unique case (w_need)
      3'd1:    w_be = 4'b0001;
      3'd2:    w_be = 4'b0011;
      3'd3:    w_be = 4'b0111;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 4; i++) begin
      w_mask[8*i +: 8] = {8{w_be[i]}};
    end
  end

  assign w_bdata = (w_res_only ? {8'b0, r_res} : w_comb[31:0])
                 & w_mask;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && (arlen != '0)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_wvalid && r_wlast && wready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command, request and credit state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_rleft <= '0;
      r_off   <= '0;
      r_bleft <= '0;
      r_user  <= '0;
      r_outst <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_gnt) - CW'(w_rx);
      if (w_acc) begin
        r_addr  <= {araddr[31:2], 2'b00};
        r_rleft <= NW'(w_nsum[LEN_W+1:2]);
        r_off   <= araddr[1:0];
        r_bleft <= arlen;
        r_user  <= aruser;
      end else begin
        if (w_gnt) begin
          r_addr  <= r_addr + 32'd4;
          r_rleft <= r_rleft - NW'(1);
        end
        if (w_beat) begin
          r_bleft <= r_bleft - LEN_W'(w_need);
        end
      end
    end
  end

  // Response FIFO.
  always_ff @(posedge clk_i) begin
    if (w_rx) begin
      r_mem[r_wp] <= mgr_rsp_i.r.rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + CW'(w_rx) - CW'(w_pop);
      if (w_rx) begin
        r_wp <= (r_wp == PW'(MAX_OUTST - 1)) ? '0 : r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= (r_rp == PW'(MAX_OUTST - 1)) ? '0 : r_rp + PW'(1);
      end
    end
  end

  // Residual bytes carried between words; upper unused bytes stay zero
  // so the next word can simply be OR-ed in above them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res   <= '0;
      r_rcnt  <= '0;
      r_first <= 1'b0;
    end else if (w_acc) begin
      r_res   <= '0;
      r_rcnt  <= '0;
      r_first <= 1'b1;
    end else if (w_res_only) begin
      r_res  <= '0;
      r_rcnt <= '0;
    end else if (w_pop) begin
      r_first <= 1'b0;
      if (w_total >= 3'd4) begin
        r_res  <= w_comb[55:32];
        r_rcnt <= w_total - 3'd4;
      end else begin
        r_res  <= w_comb[23:0];
        r_rcnt <= w_total;
      end
    end
  end

`ifdef ASCON_RDMA_ERR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_acc) begin
      r_err <= 1'b0;
    end else if (w_rx && mgr_rsp_i.r.err) begin
      r_err <= 1'b1;
    end
  end
`else
  assign r_err = 1'b0;
`endif

  // Output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wvalid <= 1'b0;
      r_wdata  <= '0;
      r_wbe    <= '0;
      r_wlast  <= 1'b0;
      r_werr   <= 1'b0;
    end else if (w_beat) begin
      r_wvalid <= 1'b1;
      r_wdata  <= w_bdata;
      r_wbe    <= w_be;
      r_wlast  <= w_blast;
      r_werr   <= w_blast & r_err;
    end else if (wready) begin
      r_wvalid <= 1'b0;
    end
  end

  assign wvalid = r_wvalid;
  assign wdata  = r_wdata;
  assign wbe    = r_wbe;
  assign wlast  = r_wlast;
  assign werr   = r_werr;
  assign wuser  = r_user;

  assign w_unused = ^{mgr_rsp_i.r.rid, mgr_rsp_i.r.err, w_nsum[1:0]};

endmodule

// File: doc/ascon_stream_read_dma.md
# ascon_stream_read_dma

Parametrised OBI read DMA engine for the user domain. It accepts a byte-granular (address, length, user) command and issues word reads on an OBI manager port, keeping a configurable number of reads in flight. It realigns the returned bytes into a word-aligned, little-endian valid/ready write stream. It feeds the Ascon datapath and any other stream consumer, and supports unaligned start, arbitrary length, zero-length commands and full output backpressure.

## Interface
Parameters:
- MAX_OUTST, default 4: maximum words in flight plus words buffered; power of two, 1..16.
- USER_W, default 6: sideband width carried from aruser to wuser.
- LEN_W, default 32: width of arlen.

Ports:
- clk_i  in  1  clock. Reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- mgr_req_o  out  mgr_obi_req_t  OBI manager request.
- mgr_rsp_i  in  mgr_obi_rsp_t  OBI manager response.
- arvalid  in  1  command valid.
- arready  out  1  command accept; high only when idle.
- araddr  in  32  start byte address.
- arlen  in  LEN_W  byte count; 0 is legal.
- aruser  in  USER_W  sideband.
- wvalid  out  1  stream beat valid.
- wready  in  1  stream beat accept.
- wdata  out  32  aligned data; disabled bytes are 0.
- wuser  out  USER_W  latched aruser.
- wbe  out  4  byte enables.
- wlast  out  1  final beat of the command.
- werr  out  1  read error flag; valid with wlast.
- busy_o  out  1  command in progress (complement of arready).

## Operation
- Idle: arready=1. Command accepted on arvalid&arready; all command fields are latched.
- Word reads: N = (araddr[1:0] + arlen + 3) >> 2, at addresses (araddr & ~3) + 4i, in order.
- Output beats: M = (arlen + 3) >> 2. Stream byte k = memory byte araddr+k; beat j holds bytes 4j..4j+3, little-endian.
- wbe = 4'b1111 except on the last beat: arlen[1:0] = 1/2/3/0 gives 0001/0011/0111/1111.
- wlast is asserted only on beat M-1. wuser holds the latched aruser for all beats.
- arlen = 0: command is accepted, no reads are issued, no beats are emitted, and the block returns idle the next cycle.
- OBI request fields: we=0, be=4'b1111, wdata=0, aid=0. req is held with a stable address until gnt.
- Credit count C = granted-but-unreturned reads + words in the response FIFO. req asserts only when C < MAX_OUTST and reads remain. rvalid is therefore never blocked.
- Response FIFO: depth MAX_OUTST, 32 bits wide, not fall-through. The realigner pops it.
- Realigner: residual register of 0-3 bytes, initialised from the alignment of araddr. The leading word's bytes below araddr[1:0] are discarded. A beat is formed when residual plus new bytes is at least 4, or when the final word has been consumed.
- Command completes on wlast&wready; the block returns idle with arready=1 the next cycle.
- rvalid received while C = 0 is discarded.
- wvalid, once asserted, holds with wdata/wbe/wlast/wuser stable until wready.

## Timing
- Reset values: arready=1, busy_o=0, mgr_req_o.req=0, wvalid=0, wlast=0, werr=0, wbe=0, wdata=0, wuser=0. C, FIFO, residual and error state are cleared.
- Reset mid-command aborts it. No further req is issued. In-flight responses are discarded under the C = 0 rule.
- First req: the cycle after command accept.
- Back-to-back grants give one read per cycle while credits remain.
- Output register: wvalid rises 2 cycles after the rvalid that completes a beat, with wready held high.
- Sustained throughput: 1 beat per cycle, given zero-wait gnt/rvalid and wready=1.
- Simultaneous gnt and FIFO pop in one cycle leave C unchanged.

## Configuration
- ASCON_RDMA_ERR_EN defined: mgr_rsp_i.r.err on any rvalid of the command sets a sticky flag. werr=1 is presented on the wlast beat. The transfer still completes with the returned data. The flag clears at command accept.
- ASCON_RDMA_ERR_EN undefined: r.err is ignored and werr is tied to 0.

## Test plan
- Memory 0x100=0x03020100, 0x104=0x07060504. Command araddr 0x100, arlen 8, wready=1 -> reads 0x100 and 0x104. Beats 0x03020100 and 0x07060504, both wbe 1111; wlast on the second.
- Command araddr 0x103, arlen 6, with 0x108=0x0B0A0908 -> 3 reads. Beat 0x06050403 with wbe 1111, then beat 0x00000807 with wbe 0011 and wlast.
- Command araddr 0x101, arlen 3 -> 1 read. Single beat 0x00030201 with wbe 0111 and wlast.
- MAX_OUTST=2, arlen 32, wready=0 -> exactly 2 grants, then req=0. wvalid holds stable. Releasing wready yields 8 beats in order.
- arlen 0 -> no req and no wvalid; arready=1 again 1 cycle after accept.
- ASCON_RDMA_ERR_EN defined, err on the second of 3 reads -> all beats are emitted and werr=1 only on the wlast beat. With the macro undefined, werr stays 0.
